snoop_bus_controller: RTL and testbench

- Shared-bus responder and arbiter for the multicore cache subsystem.
- Accepts bus requests from NUM_PROC per-core Cache instances: read miss (RdMs), write miss (WrMs) and write-back (WrBk).
- Arbitrates among requests round-robin and broadcasts snoops to all caches.
- Services each transaction from a word-addressed backing memory, then returns data, the shared flag and a ready pulse to the requesting cache.

---
 rtl/snoop_bus_controller.sv | 175 +++++++++++++++++
 tb/tb_snoop_bus_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_controller.sv
// Shared snooping bus: round-robin arbiter over per-core miss/write-back requests,
// one-cycle snoop broadcast, fixed-latency backing memory and a registered response.
module snoop_bus_controller #(
    parameter int NUM_PROC  = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 64,
    parameter int MEM_LAT   = 2,
    localparam int ID_W     = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1,
    localparam int IDX_W    = $clog2(MEM_DEPTH),
    localparam int CNT_W    = $clog2(MEM_LAT + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PROC-1:0]        req_rdms,
    input  logic [NUM_PROC-1:0]        req_wrms,
    input  logic [NUM_PROC-1:0]        req_wrbk,
    input  logic [NUM_PROC*ADDR_W-1:0] req_addr,
    input  logic [NUM_PROC*DATA_W-1:0] req_data,
    input  logic [NUM_PROC-1:0]        snoop_shared,
    output logic                       snoop_valid,
    output logic [ADDR_W-1:0]          address,
    output logic                       RdWr,
    output logic [ID_W-1:0]            proc_ID,
    output logic [DATA_W-1:0]          inValue,
    output logic                       shared,
    output logic                       readyToRead,
    output logic [NUM_PROC-1:0]        done
);

    typedef enum logic [1:0] {IDLE, SNOOP, MEM, RESP} state_t;
    localparam logic [1:0] OP_RD = 2'd0, OP_WM = 2'd1, OP_WB = 2'd2;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d, win_q, win_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                rdwr_q, rdwr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                shlat_q, shlat_d;
    logic                snoop_valid_q, snoop_valid_d;
    logic [DATA_W-1:0]   inval_q, inval_d;
    logic                shared_q, shared_d;
    logic                ready_q, ready_d;
    logic [NUM_PROC-1:0] done_q, done_d;
    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

    logic [NUM_PROC-1:0] pending;
    logic                found;
    logic [ID_W-1:0]     pick;
    logic [IDX_W-1:0]    mem_idx;
    logic                commit;

    assign pending = req_rdms | req_wrms | req_wrbk;
    assign mem_idx = addr_q[IDX_W+1:2];
    assign commit  = (state_q == MEM) && (cnt_q == CNT_W'(MEM_LAT - 1));

    // First pending core at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_PROC; k++) begin
            if (!found && pending[(int'(rr_q) + k) % NUM_PROC]) begin
                found = 1'b1;
                pick  = ID_W'((int'(rr_q) + k) % NUM_PROC);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            win_q         <= '0;
            op_q          <= OP_RD;
            addr_q        <= '0;
            data_q        <= '0;
            rdwr_q        <= 1'b0;
            cnt_q         <= '0;
            shlat_q       <= 1'b0;
            snoop_valid_q <= 1'b0;
            inval_q       <= '0;
            shared_q      <= 1'b0;
            ready_q       <= 1'b0;
            done_q        <= '0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            win_q         <= win_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            rdwr_q        <= rdwr_d;
            cnt_q         <= cnt_d;
            shlat_q       <= shlat_d;
            snoop_valid_q <= snoop_valid_d;
            inval_q       <= inval_d;
            shared_q      <= shared_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdwr_d  = rdwr_q;
        cnt_d   = cnt_q;
        shlat_d = shlat_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (found) begin
                    win_d  = pick;
                    addr_d = req_addr[int'(pick)*ADDR_W +: ADDR_W];
                    data_d = req_data[int'(pick)*DATA_W +: DATA_W];
                    if (req_wrbk[pick])      op_d = OP_WB;
                    else if (req_wrms[pick]) op_d = OP_WM;
                    else                     op_d = OP_RD;
                    rdwr_d  = !req_rdms[pick] || req_wrbk[pick] || req_wrms[pick];
                    state_d = req_wrbk[pick] ? MEM : SNOOP;
                end
            end
            SNOOP: begin
                shlat_d = |(snoop_shared & ~(NUM_PROC'(1) << win_q));
                state_d = MEM;
            end
            MEM: begin
                if (commit) state_d = RESP;
                else        cnt_d   = cnt_q + CNT_W'(1);
            end
            RESP: begin
                rr_d    = (win_q == ID_W'(NUM_PROC - 1)) ? '0 : win_q + ID_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers are loaded from the state being entered.
    always_comb begin
        snoop_valid_d = (state_d == SNOOP);
        ready_d       = (state_d == RESP);
        done_d        = ready_d ? (NUM_PROC'(1) << win_q) : '0;
        inval_d       = inval_q;
        shared_d      = shared_q;
        if (commit) begin
            inval_d  = (op_q == OP_RD) ? mem_q[mem_idx] : data_q;
            shared_d = (op_q == OP_WB) ? 1'b0 : shlat_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else if (commit && op_q != OP_RD) begin
            mem_q[mem_idx] <= data_q;
        end
    end

    assign snoop_valid = snoop_valid_q;
    assign address     = addr_q;
    assign RdWr        = rdwr_q;
    assign proc_ID     = win_q;
    assign inValue     = inval_q;
    assign shared      = shared_q;
    assign readyToRead = ready_q;
    assign done        = done_q;

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed bench for snoop_bus_controller: table of single transactions plus
// round-robin, write-back/read pairing and mid-transaction reset sequences.
module tb_snoop_bus_controller;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_rdms, req_wrms, req_wrbk, snoop_shared;
    logic [127:0] req_addr, req_data;
    logic         snoop_valid, RdWr, shared, readyToRead;
    logic [31:0]  address, inValue;
    logic [1:0]   proc_ID;
    logic [3:0]   done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          core;
        int          op;      // 0 RdMs, 1 WrMs, 2 WrBk
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  snp;
        logic [31:0] exp_val;
        logic        exp_sh;
    } vec_t;

    vec_t vecs[8];

    snoop_bus_controller dut (
        .clk(clk), .rst_n(rst_n),
        .req_rdms(req_rdms), .req_wrms(req_wrms), .req_wrbk(req_wrbk),
        .req_addr(req_addr), .req_data(req_data), .snoop_shared(snoop_shared),
        .snoop_valid(snoop_valid), .address(address), .RdWr(RdWr),
        .proc_ID(proc_ID), .inValue(inValue), .shared(shared),
        .readyToRead(readyToRead), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!readyToRead && n < 20);
        chk("resp_timeout", 64'(readyToRead), 64'd1);
    endtask

    task automatic set_req(input int core, input int op, input logic [31:0] a, input logic [31:0] d);
        req_addr[core*32 +: 32] = a;
        req_data[core*32 +: 32] = d;
        if (op == 0) req_rdms[core] = 1'b1;
        if (op == 1) req_wrms[core] = 1'b1;
        if (op == 2) req_wrbk[core] = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        logic seen;
        set_req(v.core, v.op, v.addr, v.data);
        snoop_shared = v.snp;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            step();
            n++;
            if (n == 1) begin
                chk("snoop_valid", 64'(snoop_valid), 64'(v.op != 2));
                if (v.op != 2) begin
                    chk("snoop_addr", 64'(address), 64'(v.addr));
                    chk("snoop_rdwr", 64'(RdWr), 64'(v.op != 0));
                    chk("snoop_id", 64'(proc_ID), 64'(v.core));
                end
            end
            if (readyToRead) seen = 1'b1;
        end
        chk("latency", 64'(n), (v.op == 2) ? 64'd3 : 64'd4);
        chk("inValue", 64'(inValue), 64'(v.exp_val));
        chk("shared", 64'(shared), 64'(v.exp_sh));
        chk("done", 64'(done), 64'(4'b0001 << v.core));
        chk("resp_id", 64'(proc_ID), 64'(v.core));
        chk("resp_rdwr", 64'(RdWr), 64'(v.op != 0));
        req_rdms = '0; req_wrms = '0; req_wrbk = '0;
        step();
        chk("idle_ready", 64'({readyToRead, done, snoop_valid}), 64'd0);
        chk("idle_hold", 64'(inValue), 64'(v.exp_val));
    endtask

    initial begin
        int n;
        int order[3];
        vec_t v;

        vecs[0] = '{0, 0, 32'h4,   32'h0,    4'b0000, 32'h0,    1'b0};
        vecs[1] = '{2, 1, 32'h4,   32'h5,    4'b0000, 32'h5,    1'b0};
        vecs[2] = '{1, 0, 32'h4,   32'h0,    4'b0110, 32'h5,    1'b1};
        vecs[3] = '{1, 0, 32'h4,   32'h0,    4'b0010, 32'h5,    1'b0};
        vecs[4] = '{3, 1, 32'h20,  32'h77,   4'b1111, 32'h77,   1'b1};
        vecs[5] = '{0, 0, 32'h120, 32'h0,    4'b0001, 32'h77,   1'b0};
        vecs[6] = '{2, 2, 32'hFC,  32'hDEAD, 4'b1111, 32'hDEAD, 1'b0};
        vecs[7] = '{3, 0, 32'hFC,  32'h0,    4'b0000, 32'hDEAD, 1'b0};
        order = '{0, 1, 3};

        rst_n = 1'b0;
        req_rdms = '0; req_wrms = '0; req_wrbk = '0;
        req_addr = '0; req_data = '0; snoop_shared = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 64'({snoop_valid, RdWr, shared, readyToRead, done, proc_ID}), 64'd0);
        chk("reset_data", {address, inValue}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("post_reset", 64'({snoop_valid, readyToRead, done}), 64'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Three simultaneous readers served in rotation, then pointer wrap.
        req_addr = {32'h4, 32'h4, 32'h4, 32'h4};
        req_rdms = 4'b1011;
        snoop_shared = '0;
        for (int k = 0; k < 3; k++) begin
            wait_resp(n);
            chk("rr_order", 64'(proc_ID), 64'(order[k]));
            chk("rr_done", 64'(done), 64'(4'b0001 << order[k]));
            req_rdms[proc_ID] = 1'b0;
        end
        step();
        req_rdms = 4'b0101;
        wait_resp(n);
        chk("rr_wrap", 64'(proc_ID), 64'd0);
        req_rdms[0] = 1'b0;
        wait_resp(n);
        chk("rr_next", 64'(proc_ID), 64'd2);
        req_rdms = '0;
        step();

        // Write-back and read miss from the same core.
        set_req(1, 2, 32'h8, 32'h9);
        req_rdms[1] = 1'b1;
        snoop_shared = 4'b1111;
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) chk("wb_nosnoop", 64'(snoop_valid), 64'd0);
        end while (!readyToRead && n < 20);
        chk("wb_latency", 64'(n), 64'd3);
        chk("wb_shared", 64'(shared), 64'd0);
        chk("wb_value", 64'(inValue), 64'h9);
        chk("wb_done", 64'(done), 64'b0010);
        req_wrbk = '0;
        wait_resp(n);
        chk("rd_after_wb", 64'(inValue), 64'h9);
        chk("rd_after_wb_sh", 64'(shared), 64'd1);
        chk("rd_after_wb_rw", 64'(RdWr), 64'd0);
        req_rdms = '0;
        snoop_shared = '0;
        step();

        // Reset in the middle of a write miss aborts it and clears memory.
        set_req(3, 1, 32'h104, 32'hA5);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_outs", 64'({snoop_valid, readyToRead, done}), 64'd0);
        chk("abort_addr", 64'(address), 64'd0);
        req_wrms = '0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("abort_nodone", 64'({readyToRead, done}), 64'd0);
        end
        v = '{0, 0, 32'h4, 32'h0, 4'b0000, 32'h0, 1'b0};
        run_vec(v);
        v = '{3, 1, 32'h104, 32'hA5, 4'b0000, 32'hA5, 1'b0};
        run_vec(v);
        v = '{0, 0, 32'h4, 32'h0, 4'b0000, 32'hA5, 1'b0};
        run_vec(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
